mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single main-memory port between the instruction-fetch stage and the data-memory (MEM) stage of the RV32IM pipeline. Each stage issues blocking requests and is stalled by its own busywait until the arbiter has run the transaction on the memory port. Data requests take priority; a streak counter guarantees fetch progress. Read/write codes from the control unit pass through to memory unchanged.

## Interface
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending before fetch is forced; legal range 1..15.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_read  in  1  fetch request; held until i_busywait is low.
- i_addr  in  32  fetch byte address.
- i_readdata  out  32  fetched word; valid in the cycle i_busywait is low after a request.
- i_busywait  out  1  fetch stall.
- d_read  in  4  control-unit read code: bit3 valid, [2:0] funct3.
- d_write  in  3  control-unit write code: bit2 valid, [1:0] size (00 B, 01 H, 10 W).
- d_addr  in  32  data byte address.
- d_writedata  in  32  store data.
- d_readdata  out  32  load data; valid in the cycle d_busywait is low after a read.
- d_busywait  out  1  MEM-stage stall.
- mem_read  out  4  read code to memory, 0 when idle.
- mem_write  out  3  write code to memory, 0 when idle.
- mem_addr  out  32  memory address.
- mem_writedata  out  32  memory store data.
- mem_readdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse from memory.
- grant  out  2  00 none, 01 fetch, 10 data (debug/perf).

## Operation
- Request pending: i_req = i_read; d_req = d_read[3] | d_write[2].
- States: IDLE, ACCESS, DONE.
- IDLE: if any request pending, choose owner, register owner/codes/addr/data, go to ACCESS. Otherwise stay.
- Owner choice: data if d_req, unless i_req and streak == MAX_DATA_STREAK, in which case fetch.
- Streak: on a data grant with i_req high, streak += 1. On a fetch grant, or a data grant with i_req low, streak clears to 0.
- ACCESS: mem_* driven from registers only, stable for the whole access. On mem_ack, capture mem_readdata into the owner's readdata register (reads only), go to DONE.
- DONE: one cycle. The owner's done flag is high. Return to IDLE; no grant is made in DONE.
- Fetch is issued as mem_read = 4'b1010 (LW), mem_write = 0, mem_addr = {i_addr[31:2], 2'b00}.
- Data write: if d_write[2] is high, mem_write = d_write and mem_read = 0. If both read and write are valid, the write wins and the read is dropped.
- Data read: mem_read = d_read, mem_write = 0, address passed unaligned.
- Busywait is combinational: x_busywait = x_req & ~(state==DONE & owner==x).
- Withdrawn request mid-access: the transaction still completes on memory. Read data is captured; the done cycle is harmless.
- A write never modifies d_readdata.
- Reset (asynchronous, any state): state IDLE, owner none, streak 0, mem_read/mem_write 0, mem_addr/mem_writedata 0, i_readdata/d_readdata 0, grant 00. Busywaits then follow requests; a held request restarts from IDLE.

## Timing
- Request seen in IDLE at cycle 0.
- mem strobes are asserted from cycle 1.
- mem_ack in cycle k (k ≥ 1) gives DONE in cycle k+1: busywait low and readdata valid.
- Back in IDLE at cycle k+2. A request still held there is a new transaction.
- Minimum latency: 2 stall cycles (mem_ack at cycle 1).
- The memory port is idle for at least 1 cycle (DONE) between transactions.
- mem_ack outside ACCESS is ignored.

## Test plan
- Reset: pulse RESET low with requests active. Required: all mem_* 0, grant 00, readdatas 0 immediately; i_busywait = i_read and d_busywait = d_req.
- Fetch: i_read=1, i_addr=0x0000_0043 at cycle 0; memory acks at cycle 3 with 0x00A0_0093. Required: mem_read=1010 and mem_addr=0x40 in cycles 1-3; i_busywait low and i_readdata=0x00A0_0093 in cycle 4; mem_read=0 in cycle 4.
- Collision: i_read and d_read=4'b1010 both rise in cycle 0, 1-cycle memory. Required: grant=10 first, d_busywait low at cycle 2. Fetch is granted at cycle 3 and i_busywait goes low at cycle 5.
- Starvation: MAX_DATA_STREAK=2, data and fetch requests held continuously. Required grant sequence D,D,I,D,D,I.
- Store: d_write=3'b110, d_addr=0x100, d_writedata=0xDEAD_BEEF, prior d_readdata=0x1234. Required: mem_write=110, mem_read=0000, mem_writedata=0xDEAD_BEEF. After ack, d_busywait drops and d_readdata stays 0x1234.
- Reset mid-ACCESS (before ack), fetch held. Required: strobes drop asynchronously. After release, exactly one new access is issued and the fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and the MEM stage
// Data wins by default; a streak counter forces a fetch after MAX_DATA_STREAK back-to-back data grants.
module mem_port_arbiter #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        i_read,
   input  logic [31:0] i_addr,
   output logic [31:0] i_readdata,
   output logic        i_busywait,
   input  logic [3:0]  d_read,
   input  logic [2:0]  d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_writedata,
   output logic [31:0] d_readdata,
   output logic        d_busywait,
   output logic [3:0]  mem_read,
   output logic [2:0]  mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_ack,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [1:0] OWN_NONE  = 2'b00;
   localparam logic [1:0] OWN_FETCH = 2'b01;
   localparam logic [1:0] OWN_DATA  = 2'b10;
   localparam logic [3:0] FETCH_LW  = 4'b1010;

   state_t     state;
   logic [1:0] owner;
   logic [3:0] streak;
   logic       i_req;
   logic       d_req;
   logic       force_fetch;
   logic       pick_data;
   logic       pick_fetch;

   assign i_req       = i_read;
   assign d_req       = d_read[3] | d_write[2];
   assign force_fetch = i_req && (streak == 4'(MAX_DATA_STREAK));
   assign pick_data   = d_req && !force_fetch;
   assign pick_fetch  = i_req && !pick_data;

   assign i_busywait = i_req & ~((state == DONE) && (owner == OWN_FETCH));
   assign d_busywait = d_req & ~((state == DONE) && (owner == OWN_DATA));
   assign grant      = owner;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state         <= IDLE;
         owner         <= OWN_NONE;
         streak        <= 4'd0;
         mem_read      <= 4'd0;
         mem_write     <= 3'd0;
         mem_addr      <= 32'd0;
         mem_writedata <= 32'd0;
         i_readdata    <= 32'd0;
         d_readdata    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_data) begin
                  owner         <= OWN_DATA;
                  state         <= ACCESS;
                  mem_addr      <= d_addr;
                  mem_writedata <= d_writedata;
                  // A valid write code takes the access; any read code alongside it is dropped.
                  if (d_write[2]) begin
                     mem_write <= d_write;
                     mem_read  <= 4'd0;
                  end else begin
                     mem_read  <= d_read;
                     mem_write <= 3'd0;
                  end
                  streak <= i_req ? streak + 4'd1 : 4'd0;
               end else if (pick_fetch) begin
                  owner         <= OWN_FETCH;
                  state         <= ACCESS;
                  mem_read      <= FETCH_LW;
                  mem_write     <= 3'd0;
                  mem_addr      <= i_addr & 32'hFFFF_FFFC;
                  mem_writedata <= 32'd0;
                  streak        <= 4'd0;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  if (owner == OWN_FETCH)
                     i_readdata <= mem_readdata;
                  else if (mem_read[3])
                     d_readdata <= mem_readdata;
                  mem_read      <= 4'd0;
                  mem_write     <= 3'd0;
                  mem_addr      <= 32'd0;
                  mem_writedata <= 32'd0;
                  state         <= DONE;
               end
            end
            DONE: begin
               owner <= OWN_NONE;
               state <= IDLE;
            end
            default: begin
               owner <= OWN_NONE;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        CLK;
   logic        RESET;
   logic        i_read;
   logic [31:0] i_addr;
   logic [31:0] i_readdata;
   logic        i_busywait;
   logic [3:0]  d_read;
   logic [2:0]  d_write;
   logic [31:0] d_addr;
   logic [31:0] d_writedata;
   logic [31:0] d_readdata;
   logic        d_busywait;
   logic [3:0]  mem_read;
   logic [2:0]  mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_ack;
   logic [1:0]  grant;

   int n_checks;
   int n_fail;

   mem_port_arbiter #(.MAX_DATA_STREAK(2)) dut (
      .CLK(CLK), .RESET(RESET),
      .i_read(i_read), .i_addr(i_addr), .i_readdata(i_readdata), .i_busywait(i_busywait),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_writedata(d_writedata),
      .d_readdata(d_readdata), .d_busywait(d_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ack(mem_ack),
      .grant(grant)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        i_read;
      logic [31:0] i_addr;
      logic [3:0]  d_read;
      logic [2:0]  d_write;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        ack;
      logic [31:0] rdata;
      logic [3:0]  e_mrd;
      logic [2:0]  e_mwr;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic [1:0]  e_grant;
      logic        e_ibw;
      logic        e_dbw;
      logic [31:0] e_irdata;
      logic [31:0] e_drdata;
   } vec_t;

   localparam int NV = 21;
   vec_t tab [NV];
   vec_t v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive inputs just after the edge, compare outputs mid-cycle.
   task automatic run_vec(input int idx, input vec_t t);
      @(posedge CLK);
      #1;
      i_read       = t.i_read;
      i_addr       = t.i_addr;
      d_read       = t.d_read;
      d_write      = t.d_write;
      d_addr       = t.d_addr;
      d_writedata  = t.d_wdata;
      mem_ack      = t.ack;
      mem_readdata = t.rdata;
      #2;
      chk($sformatf("v%0d mem_read", idx), 32'(mem_read), 32'(t.e_mrd));
      chk($sformatf("v%0d mem_write", idx), 32'(mem_write), 32'(t.e_mwr));
      chk($sformatf("v%0d mem_addr", idx), mem_addr, t.e_maddr);
      chk($sformatf("v%0d mem_writedata", idx), mem_writedata, t.e_mwdata);
      chk($sformatf("v%0d grant", idx), 32'(grant), 32'(t.e_grant));
      chk($sformatf("v%0d i_busywait", idx), 32'(i_busywait), 32'(t.e_ibw));
      chk($sformatf("v%0d d_busywait", idx), 32'(d_busywait), 32'(t.e_dbw));
      chk($sformatf("v%0d i_readdata", idx), i_readdata, t.e_irdata);
      chk($sformatf("v%0d d_readdata", idx), d_readdata, t.e_drdata);
   endtask

   initial begin
      logic [1:0] gseq [6];
      logic [1:0] gexp [6];
      int         ng;
      int         n_acc;

      n_checks = 0;
      n_fail   = 0;

      // fetch: LW at 0x43 -> aligned 0x40, ack in cycle 3
      tab[0]  = '{1'b1, 32'h43, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0};
      tab[1]  = '{1'b1, 32'h43, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'hA, 3'd0, 32'h40, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0};
      tab[2]  = '{1'b1, 32'h43, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'hA, 3'd0, 32'h40, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0};
      tab[3]  = '{1'b1, 32'h43, 4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h00A00093, 4'hA, 3'd0, 32'h40, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0};
      tab[4]  = '{1'b1, 32'h43, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'h0, 3'd0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      tab[5]  = '{1'b0, 32'h0,  4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'hBAD,      4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h00A00093, 32'h0};
      // collision: data first, fetch after the DONE cycle
      tab[6]  = '{1'b1, 32'h80, 4'hA, 3'd0, 32'h200, 32'h0, 1'b0, 32'h0,      4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 32'h00A00093, 32'h0};
      tab[7]  = '{1'b1, 32'h80, 4'hA, 3'd0, 32'h200, 32'h0, 1'b1, 32'h1234,   4'hA, 3'd0, 32'h200, 32'h0, 2'd2, 1'b1, 1'b1, 32'h00A00093, 32'h0};
      tab[8]  = '{1'b1, 32'h80, 4'hA, 3'd0, 32'h200, 32'h0, 1'b0, 32'h0,      4'h0, 3'd0, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0, 32'h00A00093, 32'h1234};
      tab[9]  = '{1'b1, 32'h80, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h00A00093, 32'h1234};
      tab[10] = '{1'b1, 32'h80, 4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h33334444, 4'hA, 3'd0, 32'h80, 32'h0, 2'd1, 1'b1, 1'b0, 32'h00A00093, 32'h1234};
      tab[11] = '{1'b1, 32'h80, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'h0, 3'd0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h33334444, 32'h1234};
      tab[12] = '{1'b0, 32'h0,  4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,        4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h33334444, 32'h1234};
      // store word: d_readdata must keep the earlier load value
      tab[13] = '{1'b0, 32'h0, 4'h0, 3'd6, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,       4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h33334444, 32'h1234};
      tab[14] = '{1'b0, 32'h0, 4'h0, 3'd6, 32'h100, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFF, 4'h0, 3'd6, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 32'h33334444, 32'h1234};
      tab[15] = '{1'b0, 32'h0, 4'h0, 3'd6, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,       4'h0, 3'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h33334444, 32'h1234};
      tab[16] = '{1'b0, 32'h0, 4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h77,               4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h33334444, 32'h1234};
      // read and halfword write both valid: write wins, read dropped
      tab[17] = '{1'b0, 32'h0, 4'hA, 3'd5, 32'h102, 32'hCAFE, 1'b0, 32'h0,     4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h33334444, 32'h1234};
      tab[18] = '{1'b0, 32'h0, 4'hA, 3'd5, 32'h102, 32'hCAFE, 1'b1, 32'hAAAA,  4'h0, 3'd5, 32'h102, 32'hCAFE, 2'd2, 1'b0, 1'b1, 32'h33334444, 32'h1234};
      tab[19] = '{1'b0, 32'h0, 4'hA, 3'd5, 32'h102, 32'hCAFE, 1'b0, 32'h0,     4'h0, 3'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h33334444, 32'h1234};
      tab[20] = '{1'b0, 32'h0, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0,          4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h33334444, 32'h1234};

      // reset held with requests active
      RESET = 1'b0;
      i_read = 1'b1; i_addr = 32'h10; d_read = 4'hA; d_write = 3'd0;
      d_addr = 32'h20; d_writedata = 32'h0; mem_ack = 1'b0; mem_readdata = 32'h0;
      #1;
      chk("rst mem_read", 32'(mem_read), 32'd0);
      chk("rst mem_write", 32'(mem_write), 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst grant", 32'(grant), 32'd0);
      chk("rst i_readdata", i_readdata, 32'd0);
      chk("rst d_readdata", d_readdata, 32'd0);
      chk("rst i_busywait", 32'(i_busywait), 32'd1);
      chk("rst d_busywait read", 32'(d_busywait), 32'd1);
      d_read = 4'h0; d_write = 3'd4;
      #1;
      chk("rst d_busywait write", 32'(d_busywait), 32'd1);
      i_read = 1'b0; d_write = 3'd0;
      #1;
      chk("rst i_busywait idle", 32'(i_busywait), 32'd0);
      chk("rst d_busywait idle", 32'(d_busywait), 32'd0);
      @(posedge CLK);
      #3;
      RESET = 1'b1;

      for (int k = 0; k < NV; k++)
         run_vec(k, tab[k]);

      // reset asserted mid-access, fetch held throughout
      n_acc = 0;
      v = '{1'b1, 32'h104, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h33334444, 32'h1234};
      run_vec(100, v);
      v = '{1'b1, 32'h104, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 4'hA, 3'd0, 32'h104, 32'h0, 2'd1, 1'b1, 1'b0, 32'h33334444, 32'h1234};
      run_vec(101, v);
      #2;
      RESET = 1'b0;
      #1;
      chk("midrst mem_read", 32'(mem_read), 32'd0);
      chk("midrst mem_addr", mem_addr, 32'd0);
      chk("midrst grant", 32'(grant), 32'd0);
      chk("midrst i_readdata", i_readdata, 32'd0);
      chk("midrst d_readdata", d_readdata, 32'd0);
      chk("midrst i_busywait", 32'(i_busywait), 32'd1);
      #2;
      RESET = 1'b1;
      v = '{1'b1, 32'h104, 4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h55, 4'hA, 3'd0, 32'h104, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0};
      run_vec(102, v);
      if (mem_read != 4'h0) n_acc++;
      v = '{1'b1, 32'h104, 4'h0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 3'd0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 32'h55, 32'h0};
      run_vec(103, v);
      if (mem_read != 4'h0) n_acc++;
      v = '{1'b0, 32'h0, 4'h0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h99, 4'h0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h55, 32'h0};
      run_vec(104, v);
      if (mem_read != 4'h0) n_acc++;
      chk("midrst access count", 32'(n_acc), 32'd1);

      // starvation with MAX_DATA_STREAK=2: D,D,I,D,D,I
      gexp = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};
      for (int k = 0; k < 6; k++) gseq[k] = 2'd0;
      ng = 0;
      @(posedge CLK);
      #1;
      i_read = 1'b1; i_addr = 32'h8; d_read = 4'hA; d_addr = 32'h300;
      mem_ack = 1'b1; mem_readdata = 32'h1;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         @(posedge CLK);
         #3;
         if (mem_read != 4'h0) begin
            gseq[ng] = grant;
            ng++;
         end
      end
      for (int k = 0; k < 6; k++)
         chk($sformatf("starve grant %0d", k), 32'(gseq[k]), 32'(gexp[k]));
      i_read = 1'b0; d_read = 4'h0; mem_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
